// File: rtl/div_unit_pkg.sv
// Shared constants for the iterative divider: FSM encodings and iteration counter width.
package div_unit_pkg;
    localparam logic [1:0] DIV_IDLE   = 2'd0;
    localparam logic [1:0] DIV_BUSY   = 2'd1;
    localparam logic [1:0] DIV_DONE   = 2'd2;
    localparam int         DIV_CNT_WD = 5;
endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate; used both for operand magnitude and result sign fix.
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    // Negate when requested, otherwise pass through unchanged.
    always_comb begin
        if (i_neg) begin
            o_val = ~i_val + WIDTH'(1);
        end else begin
            o_val = i_val;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU; one quotient bit per BUSY cycle,
// results registered and held in DONE until the next accepted start, flush or reset.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] div_dividend,
    input  logic [WIDTH-1:0] div_divisor,
    input  logic             div_flush,
    output logic             div_busy,
    output logic             div_ready,
    output logic [WIDTH-1:0] div_result,
    output logic [WIDTH-1:0] mod_result
);

    logic [1:0]            r_state;
    logic [DIV_CNT_WD-1:0] r_cnt;
    logic [WIDTH:0]        r_rem;
    logic [WIDTH-1:0]      r_quo;
    logic [WIDTH-1:0]      r_dvs;
    logic                  r_qsign;
    logic                  r_rsign;
    logic                  r_busy;
    logic                  r_ready;
    logic [WIDTH-1:0]      r_div_result;
    logic [WIDTH-1:0]      r_mod_result;

    logic [WIDTH-1:0]      w_dvd_mag;
    logic [WIDTH-1:0]      w_dvs_mag;
    logic [WIDTH:0]        w_rem_sh;
    logic [WIDTH+1:0]      w_trial;
    logic                  w_fits;
    logic [WIDTH:0]        w_rem_nx;
    logic [WIDTH-1:0]      w_quo_nx;
    logic [WIDTH-1:0]      w_quo_fix;
    logic [WIDTH-1:0]      w_rem_fix;

    div_abs_neg #(.WIDTH(WIDTH)) u_dvd_abs (
        .i_val (div_dividend),
        .i_neg (div_signed & div_dividend[WIDTH-1]),
        .o_val (w_dvd_mag)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_dvs_abs (
        .i_val (div_divisor),
        .i_neg (div_signed & div_divisor[WIDTH-1]),
        .o_val (w_dvs_mag)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_quo_fix (
        .i_val (w_quo_nx),
        .i_neg (r_qsign),
        .o_val (w_quo_fix)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_rem_fix (
        .i_val (w_rem_nx[WIDTH-1:0]),
        .i_neg (r_rsign),
        .o_val (w_rem_fix)
    );

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor magnitude.
    always_comb begin
        w_rem_sh = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_trial  = {1'b0, w_rem_sh} - {2'b00, r_dvs};
        w_fits   = ~w_trial[WIDTH+1];
        if (w_fits) begin
            w_rem_nx = w_trial[WIDTH:0];
        end else begin
            w_rem_nx = w_rem_sh;
        end
        w_quo_nx = {r_quo[WIDTH-2:0], w_fits};
    end

    // FSM, iteration counter and datapath registers; flush overrides any start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= DIV_IDLE;
            r_cnt        <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_dvs        <= '0;
            r_qsign      <= 1'b0;
            r_rsign      <= 1'b0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b0;
            r_div_result <= '0;
            r_mod_result <= '0;
        end else if (div_flush) begin
            r_state <= DIV_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE, DIV_DONE: begin
                    if (div_start) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_dvd_mag;
                        r_dvs   <= w_dvs_mag;
                        r_qsign <= div_signed & (div_dividend[WIDTH-1] ^ div_divisor[WIDTH-1]);
                        r_rsign <= div_signed & div_dividend[WIDTH-1];
                        if (div_divisor == '0) begin
                            // Divide by zero bypasses iteration; remainder is the raw dividend.
                            r_state      <= DIV_DONE;
                            r_busy       <= 1'b0;
                            r_ready      <= 1'b1;
                            r_div_result <= {WIDTH{1'b1}};
                            r_mod_result <= div_dividend;
                        end else begin
                            r_state <= DIV_BUSY;
                            r_busy  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end else begin
                        r_state <= r_state;
                    end
                end
                DIV_BUSY: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + DIV_CNT_WD'(1);
                    if (r_cnt == DIV_CNT_WD'(WIDTH - 1)) begin
                        r_state      <= DIV_DONE;
                        r_busy       <= 1'b0;
                        r_ready      <= 1'b1;
                        r_div_result <= w_quo_fix;
                        r_mod_result <= w_rem_fix;
                    end else begin
                        r_state <= DIV_BUSY;
                    end
                end
                default: begin
                    r_state <= DIV_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign div_busy   = r_busy;
    assign div_ready  = r_ready;
    assign div_result = r_div_result;
    assign mod_result = r_mod_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic        div_flush;
    logic        div_busy;
    logic        div_ready;
    logic [31:0] div_result;
    logic [31:0] mod_result;

    int n_checks = 0;
    int n_pass   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .div_start    (div_start),
        .div_signed   (div_signed),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_flush    (div_flush),
        .div_busy     (div_busy),
        .div_ready    (div_ready),
        .div_result   (div_result),
        .mod_result   (mod_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Execute must never start a new divide while one is in flight.
    always @(posedge clk) begin
        if (!reset && div_busy) begin
            assert (!div_start) else $error("FAIL protocol: div_start while busy");
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference: truncating division, remainder takes dividend sign, special zero/overflow rules.
    function automatic void ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sg) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Issue one divide from the current cycle and follow it to div_ready.
    task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int cyc;
        int busy_n;
        int exp_lat;
        int exp_busy;
        exp_lat  = (b == 32'd0) ? 1 : 33;
        exp_busy = (b == 32'd0) ? 0 : 32;
        div_start    = 1'b1;
        div_signed   = sg;
        div_dividend = a;
        div_divisor  = b;
        @(posedge clk); #1;
        div_start = 1'b0;
        cyc    = 1;
        busy_n = 0;
        if (b != 32'd0) begin
            check({tag, " ready_drop"}, {31'd0, div_ready}, 32'd0);
        end
        while (div_ready !== 1'b1 && cyc < 40) begin
            if (div_busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " busy_cycles"}, busy_n, exp_busy);
        check({tag, " busy_at_ready"}, {31'd0, div_busy}, 32'd0);
        check({tag, " quotient"}, div_result, eq);
        check({tag, " remainder"}, mod_result, er);
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;

        reset        = 1'b1;
        div_start    = 1'b0;
        div_signed   = 1'b0;
        div_dividend = 32'd0;
        div_divisor  = 32'd0;
        div_flush    = 1'b0;
        #3;
        check("reset busy", {31'd0, div_busy}, 32'd0);
        check("reset ready", {31'd0, div_ready}, 32'd0);
        check("reset quotient", div_result, 32'd0);
        check("reset remainder", mod_result, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        run_op("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("s5/0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run_op("u5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
        run_op("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // Flush in BUSY cycle 10, then restart in cycle 11.
        div_start    = 1'b1;
        div_signed   = 1'b0;
        div_dividend = 32'd100;
        div_divisor  = 32'd7;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("flush pre busy", {31'd0, div_busy}, 32'd1);
        div_flush = 1'b1;
        @(posedge clk); #1;
        div_flush = 1'b0;
        check("flush busy", {31'd0, div_busy}, 32'd0);
        check("flush ready", {31'd0, div_ready}, 32'd0);
        run_op("u9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Flush together with start: start is dropped.
        div_start    = 1'b1;
        div_flush    = 1'b1;
        div_dividend = 32'd50;
        div_divisor  = 32'd5;
        @(posedge clk); #1;
        div_start = 1'b0;
        div_flush = 1'b0;
        check("flush+start busy", {31'd0, div_busy}, 32'd0);
        check("flush+start ready", {31'd0, div_ready}, 32'd0);
        @(posedge clk); #1;
        check("flush+start dropped", {31'd0, div_busy}, 32'd0);

        // Async reset between edges while busy.
        run_op("u1000/9", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1);
        div_start    = 1'b1;
        div_dividend = 32'd77;
        div_divisor  = 32'd4;
        @(posedge clk); #1;
        div_start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        #1;
        check("areset busy", {31'd0, div_busy}, 32'd0);
        check("areset ready", {31'd0, div_ready}, 32'd0);
        check("areset quotient", div_result, 32'd0);
        check("areset remainder", mod_result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Randomized back-to-back operations from DONE.
        for (int i = 0; i < 30; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if (b != 32'd0 && $urandom_range(0, 1) == 1) b = -b;
            ref_div(sg, a, b, q, r);
            run_op($sformatf("rnd%0d", i), sg, a, b, q, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit radix-2 integer divider for DIV.W/DIV.WU/MOD.W/MOD.WU.
- Launched by the execute stage; its div_result/mod_result feed the memory stage's result mux directly.
- Execute holds the divide instruction (does not hand it to memory) until div_ready is high, so memory samples a stable result.
- Cancelled by the same flush sources that clear the memory stage.

Parameters:
- WIDTH, 32, operand/result width; the core instantiates at 32 only.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- div_start  input  1  one-cycle request from execute; sampled only when not busy.
- div_signed  input  1  1 = signed (DIV.W/MOD.W), 0 = unsigned.
- div_dividend  input  WIDTH  dividend, sampled with div_start.
- div_divisor  input  WIDTH  divisor, sampled with div_start.
- div_flush  input  1  OR of excp/ertn/refetch/icacop/idle flush; aborts operation.
- div_busy  output  1  operation in progress; execute must not issue a new start.
- div_ready  output  1  div_result/mod_result valid and stable.
- div_result  output  WIDTH  quotient.
- mod_result  output  WIDTH  remainder.

Behaviour:
- Reset (async): state IDLE; div_busy=0, div_ready=0, div_result=0, mod_result=0; counter=0.
- States: IDLE, BUSY, DONE.
- Start acceptance:
  - div_start is accepted in IDLE or DONE when div_flush=0.
  - Accepting clears div_ready in the same edge and latches operand magnitudes, quotient sign (dividend sign XOR divisor sign, signed mode only) and remainder sign (dividend sign, signed mode only).
  - div_start while BUSY is ignored (protocol violation; assertion in bench).
- Divisor zero fast path (accept edge): go directly to DONE with div_result=32'hFFFFFFFF and mod_result=dividend (raw, unnegated), in both signed and unsigned modes. Result valid one cycle after the start cycle.
- Normal path:
  - Enter BUSY with counter=0.
  - Each BUSY cycle performs one restoring step on the magnitudes: shift {rem,quo} left by 1, trial-subtract |divisor| from rem (WIDTH+1-bit compare), keep the result if non-negative and set the quotient LSB to 1.
  - counter increments each BUSY cycle; at counter==WIDTH-1 apply sign fix (two's-complement negate the quotient/remainder where the latched sign is 1), register the results and go to DONE.
  - Latency: start in cycle 0 -> div_ready high from cycle WIDTH+1 (33).
- DONE: div_ready=1 and results held until the next accepted start, flush, or reset. div_busy=1 only in BUSY.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> div_result=0x80000000, mod_result=0. Falls out of the magnitude algorithm; no special case.
- Flush: div_flush=1 in any state -> next edge IDLE, div_busy=0, div_ready=0. div_result/mod_result keep their old register values and are don't-care. Flush beats a simultaneous div_start (the start is dropped).
- Width rules:
  - Magnitude = two's-complement negate if signed and MSB set; 0x80000000 magnitude is 0x80000000 unsigned.
  - Remainder datapath is WIDTH+1 bits internally; outputs truncated to WIDTH.
- Output results are registered only; no combinational path from inputs to div_result/mod_result/div_ready.

Decomposition:
- Shared header (alongside mycpu.h): state encodings DIV_IDLE/DIV_BUSY/DIV_DONE (2-bit) and DIV_CNT_WD (5).
- One natural sub-module: div_abs_neg (signed magnitude / conditional negate, WIDTH-parameterised), instantiated for operand prep and sign fix.
- FSM, counter and shift datapath stay in div_unit.

Test Plan:
- Unsigned 100 / 7 -> busy cycles 1-32, ready at cycle 33, div_result=14, mod_result=2.
- Signed -7 / 2 (0xFFFFFFF9 / 2) -> div_result=0xFFFFFFFD, mod_result=0xFFFFFFFF; signed 7 / -2 -> 0xFFFFFFFD, 1.
- Signed 0x80000000 / 0xFFFFFFFF -> div_result=0x80000000, mod_result=0. Unsigned same operands -> div_result=0, mod_result=0x80000000.
- Divide by zero 5 / 0 (signed and unsigned) -> ready at cycle 1, div_result=0xFFFFFFFF, mod_result=5, busy never asserted.
- div_flush at cycle 10 of BUSY -> cycle 11 IDLE, busy=0, ready=0. Start 9 / 3 in cycle 11 -> ready at cycle 44 with 3, 0. Flush+start same cycle -> start dropped.
- reset asserted asynchronously mid-BUSY (between edges) -> busy, ready and results 0 immediately. Back-to-back start in DONE -> ready drops next edge, new result after 33 cycles.
